// File: rtl/run_monitor.sv
// Run controller for the CPU core: holds it in reset, runs until completed or budget, then dumps all registers.
// Optional build macro RUN_MONITOR_SNAPSHOT_EN dumps from a register snapshot taken on DUMP entry.
module run_monitor #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NREGS      = 32,
   parameter int unsigned MAX_CLOCKS = 100000,
   parameter int unsigned CNT_W      = 32,
   localparam int unsigned IDX_W     = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  cpu_rstn,
   input  logic                  completed,
   input  logic [NREGS*XLEN-1:0] reg_flat,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [IDX_W-1:0]      dump_idx,
   output logic [XLEN-1:0]       dump_data,
   output logic                  dump_last,
   output logic [CNT_W-1:0]      cycle_count,
   output logic                  timeout,
   output logic                  busy,
   output logic                  done
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREGS - 1);
   localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(MAX_CLOCKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    count_d;
   logic                timeout_d;
   logic [IDX_W-1:0]    idx_d;
   logic [XLEN-1:0]     regs [NREGS];

   // Unpack the flat register bus into an indexable array
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs[i] = reg_flat[i*XLEN +: XLEN];
      end
   end

   // Next-state and next-value logic
   always_comb begin
      state_d   = state;
      count_d   = cycle_count;
      timeout_d = timeout;
      idx_d     = dump_idx;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               count_d   = '0;
               timeout_d = 1'b0;
               idx_d     = '0;
            end
         end
         RUN: begin
            if (cycle_count != CNT_MAX) begin
               count_d = cycle_count + CNT_W'(1);
            end
            // completed takes priority over the budget in the same cycle
            if (completed) begin
               state_d = DUMP;
            end else if (cycle_count == LAST_CLK) begin
               state_d   = DUMP;
               timeout_d = 1'b1;
            end
         end
         DUMP: begin
            if (dump_valid && dump_ready) begin
               if (dump_idx == LAST_IDX) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = dump_idx + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs, decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cycle_count <= '0;
         timeout     <= 1'b0;
         dump_idx    <= '0;
         cpu_rstn    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         dump_valid  <= 1'b0;
         dump_last   <= 1'b0;
      end else begin
         state       <= state_d;
         cycle_count <= count_d;
         timeout     <= timeout_d;
         dump_idx    <= idx_d;
         cpu_rstn    <= (state_d == RUN);
         busy        <= (state_d == RUN) || (state_d == DUMP);
         done        <= (state_d == DONE);
         dump_valid  <= (state_d == DUMP);
         dump_last   <= (state_d == DUMP) && (idx_d == LAST_IDX);
      end
   end

`ifdef RUN_MONITOR_SNAPSHOT_EN
   logic [XLEN-1:0] snap [NREGS];
   logic            capture;

   assign capture = (state == RUN) && (state_d == DUMP);

   // Freeze the register file as the core is put back into reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            snap[i] <= '0;
         end
      end else if (capture) begin
         snap <= regs;
      end
   end

   assign dump_data = snap[dump_idx];
`else
   assign dump_data = regs[dump_idx];
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Randomized self-checking bench for run_monitor with a queue-based reference model.
module tb_run_monitor;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned MAXC  = 20;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = $clog2(NREGS);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst, start, completed, dump_ready;
   logic [XLEN-1:0]       regs [NREGS];
   logic [NREGS*XLEN-1:0] reg_flat;
   logic                  cpu_rstn, dump_valid, dump_last, timeout, busy, done;
   logic [IDX_W-1:0]      dump_idx;
   logic [XLEN-1:0]       dump_data;
   logic [CNT_W-1:0]      cycle_count;

   always_comb begin
      for (int i = 0; i < NREGS; i++) reg_flat[i*XLEN +: XLEN] = regs[i];
   end

   run_monitor #(.XLEN(XLEN), .NREGS(NREGS), .MAX_CLOCKS(MAXC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cpu_rstn(cpu_rstn), .completed(completed),
      .reg_flat(reg_flat), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
      .cycle_count(cycle_count), .timeout(timeout), .busy(busy), .done(done));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is a count of elapsed cycles; a dump is a queue of pending indices
   bit  m_live = 1'b0;
   bit  m_run = 1'b0, m_done = 1'b0, m_timeout = 1'b0;
   int  m_count = 0;
   int  q[$];
   int  xfers = 0;
`ifdef RUN_MONITOR_SNAPSHOT_EN
   logic [XLEN-1:0] m_snap [NREGS];
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_live = 1'b1; m_run = 1'b0; m_done = 1'b0; m_timeout = 1'b0; m_count = 0;
         q.delete();
      end else if (m_run) begin
         if (m_count < (1 << CNT_W) - 1) m_count++;
         if (completed || m_count == int'(MAXC)) begin
            m_run     = 1'b0;
            m_timeout = !completed;
            for (int i = 0; i < NREGS; i++) q.push_back(i);
`ifdef RUN_MONITOR_SNAPSHOT_EN
            m_snap = regs;
`endif
         end
      end else if (q.size() > 0) begin
         if (dump_ready) begin
            void'(q.pop_front());
            xfers++;
            if (q.size() == 0) m_done = 1'b1;
         end
      end else if (start) begin
         m_run = 1'b1; m_done = 1'b0; m_timeout = 1'b0; m_count = 0;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_live) begin
         chk("cpu_rstn",    64'(cpu_rstn),    64'(m_run));
         chk("busy",        64'(busy),        64'(m_run || q.size() > 0));
         chk("done",        64'(done),        64'(m_done));
         chk("dump_valid",  64'(dump_valid),  64'(q.size() > 0));
         chk("cycle_count", 64'(cycle_count), 64'(m_count));
         chk("timeout",     64'(timeout),     64'(m_timeout));
         if (q.size() > 0) begin
            chk("dump_idx",  64'(dump_idx),  64'(q[0]));
            chk("dump_last", 64'(dump_last), 64'(q[0] == int'(NREGS) - 1));
`ifdef RUN_MONITOR_SNAPSHOT_EN
            chk("dump_data", 64'(dump_data), 64'(m_snap[q[0]]));
`else
            chk("dump_data", 64'(dump_data), 64'(regs[q[0]]));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_regs_linear();
      for (int i = 0; i < NREGS; i++) regs[i] = XLEN'(i * 3);
   endtask

   task automatic chk_reset_values();
      chk("rst_cpu_rstn",    64'(cpu_rstn),    64'(0));
      chk("rst_cycle_count", 64'(cycle_count), 64'(0));
      chk("rst_timeout",     64'(timeout),     64'(0));
      chk("rst_dump_valid",  64'(dump_valid),  64'(0));
      chk("rst_dump_idx",    64'(dump_idx),    64'(0));
      chk("rst_dump_last",   64'(dump_last),   64'(0));
      chk("rst_busy",        64'(busy),        64'(0));
      chk("rst_done",        64'(done),        64'(0));
   endtask

   // Start pulse, then assert completed in RUN cycle comp_at (0: never)
   task automatic run_case(input int comp_at, input bit noisy);
      int n;
      completed  = 1'b0;
      dump_ready = 1'b0;
      start      = 1'b1;
      tick();
      start = 1'b0;
      n = (comp_at == 0) ? int'(MAXC) : comp_at;
      for (int c = 1; c <= n; c++) begin
         completed = (c == comp_at);
         if (noisy) start = 1'($urandom % 2);
         tick();
      end
      completed = 1'b0;
      start     = 1'b0;
   endtask

   // Drain the dump; mode 0 always ready, 1 ready pattern 1,0,0,1, 2 random with register churn
   task automatic wait_done(input int mode, input int budget);
      int k;
      int pat [4];
      pat = '{1, 0, 0, 1};
      k = 0;
      while (!done && k < budget) begin
         case (mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = 1'(pat[k % 4]);
            default: begin
               dump_ready = 1'($urandom % 2);
               if ($urandom % 4 == 0) regs[$urandom % NREGS] = $urandom;
            end
         endcase
         tick();
         k++;
      end
      dump_ready = 1'b0;
      chk("wait_done", 64'(done), 64'(1));
   endtask

   initial begin
      int comp;
      rst = 1'b1; start = 1'b0; completed = 1'b0; dump_ready = 1'b0;
      set_regs_linear();
      repeat (3) tick();
      chk_reset_values();
      rst = 1'b0;
      tick();

      // Normal completion on the 10th RUN cycle
      xfers = 0;
      run_case(10, 1'b0);
      chk("norm_count",   64'(cycle_count), 64'(10));
      chk("norm_timeout", 64'(timeout),     64'(0));
      chk("norm_rstn",    64'(cpu_rstn),    64'(0));
      chk("norm_word0",   64'(dump_data),   64'(0));
      wait_done(0, 100);
      chk("norm_xfers",   64'(xfers),       64'(32));

      // Budget expiry
      xfers = 0;
      run_case(0, 1'b0);
      chk("to_count",   64'(cycle_count), 64'(MAXC));
      chk("to_timeout", 64'(timeout),     64'(1));
      chk("to_rstn",    64'(cpu_rstn),    64'(0));
      wait_done(0, 100);
      chk("to_xfers",   64'(xfers),       64'(32));
      chk("to_held",    64'(timeout),     64'(1));

      // Back-pressure
      xfers = 0;
      run_case(5, 1'b0);
      wait_done(1, 400);
      chk("bp_xfers", 64'(xfers), 64'(32));

      // completed on the same cycle the budget runs out
      xfers = 0;
      run_case(int'(MAXC), 1'b0);
      chk("sim_count",   64'(cycle_count), 64'(MAXC));
      chk("sim_timeout", 64'(timeout),     64'(0));
      wait_done(0, 100);

      // Reset after five transfers, then a fresh full dump
      xfers = 0;
      run_case(3, 1'b0);
      dump_ready = 1'b1;
      repeat (5) tick();
      dump_ready = 1'b0;
      chk("mid_xfers", 64'(xfers),    64'(5));
      chk("mid_idx",   64'(dump_idx), 64'(5));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_values();
      xfers = 0;
      run_case(4, 1'b0);
      chk("restart_idx", 64'(dump_idx), 64'(0));
      wait_done(0, 100);
      chk("restart_xfers", 64'(xfers), 64'(32));

      // Registers cleared after DUMP entry
      set_regs_linear();
      run_case(7, 1'b0);
      for (int i = 0; i < NREGS; i++) regs[i] = '0;
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
`ifdef RUN_MONITOR_SNAPSHOT_EN
      chk("clear_word1", 64'(dump_data), 64'(3));
`else
      chk("clear_word1", 64'(dump_data), 64'(0));
`endif
      wait_done(0, 100);

      // Randomized runs
      repeat (20) begin
         for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
         comp  = int'($urandom_range(1, MAXC + 5));
         xfers = 0;
         run_case(comp, 1'b1);
         chk("rnd_count",   64'(cycle_count), 64'((comp < int'(MAXC)) ? comp : int'(MAXC)));
         chk("rnd_timeout", 64'(timeout),     64'(comp > int'(MAXC)));
         wait_done(2, 800);
         chk("rnd_xfers",   64'(xfers),       64'(32));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller for the CPU core.
- Controls the core's reset, counts clocks until the core asserts completed or a cycle budget expires, then streams every architectural register out over a valid/ready channel.
- Successor of the simulation-only run/dump harness: parametrised in register width, register count and cycle budget; adds a timeout flag and a back-pressured dump.
- Sits between the core and a host/debug sink (UART bridge or bench).

Parameters:
- XLEN, 32, width of one register.
- NREGS, 32, number of registers dumped; must be >= 2.
- MAX_CLOCKS, 100000, cycle budget before timeout; must be >= 1.
- CNT_W, 32, width of cycle counter; 2**CNT_W > MAX_CLOCKS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a run when IDLE or DONE.
- cpu_rstn  out  1  reset to core, active-low; 0 except in RUN.
- completed  in  1  core finished flag.
- reg_flat  in  NREGS*XLEN  core registers; reg i at bits [i*XLEN +: XLEN].
- dump_valid  out  1  dump word available.
- dump_ready  in  1  sink accepts word.
- dump_idx  out  $clog2(NREGS)  register index of current word.
- dump_data  out  XLEN  register value.
- dump_last  out  1  high with index NREGS-1.
- cycle_count  out  CNT_W  clocks spent in RUN, held after run.
- timeout  out  1  run ended by budget, not by completed.
- busy  out  1  state is RUN or DUMP.
- done  out  1  state is DONE.

Behaviour:
- States: IDLE, RUN, DUMP, DONE.
- Reset values: state=IDLE, cpu_rstn=0, cycle_count=0, timeout=0, dump_valid=0, dump_idx=0, dump_last=0, busy=0, done=0. dump_data is don't-care while dump_valid=0.
- IDLE/DONE + start: next cycle enters RUN; cycle_count<=0, timeout<=0, dump_idx<=0; cpu_rstn=1 from that cycle.
- start while RUN or DUMP: ignored.
- RUN, each cycle:
  - cycle_count increments.
  - If completed=1: go to DUMP; the count includes that cycle.
  - Else if cycle_count reaches MAX_CLOCKS-1 (i.e., MAX_CLOCKS cycles spent): timeout<=1, go to DUMP.
  - completed and the budget hit in the same cycle: completed wins, timeout=0.
- cpu_rstn drops to 0 on the cycle DUMP is entered, freezing the core.
- DUMP:
  - dump_valid=1 every cycle.
  - Transfer on dump_valid & dump_ready; dump_idx increments on each transfer.
  - Index, data and last remain stable while dump_ready=0.
  - Transfer with dump_last=1: go to DONE; dump_valid=0 next cycle.
  - No bubbles: back-to-back ready produces NREGS words in NREGS cycles.
- DONE: done=1; cycle_count and timeout held until the next start.
- rst mid-run or mid-dump: immediate return to reset values next edge; no partial dump is resumed.
- cycle_count saturates at all-ones; it never wraps.

Optional Feature:
- Macro RUN_MONITOR_SNAPSHOT_EN.
- Defined:
  - On the RUN->DUMP transition edge, reg_flat is captured into an internal NREGS x XLEN array.
  - dump_data is read from the snapshot, so the dump is immune to later changes of reg_flat (e.g., core reset clearing registers).
  - Snapshot cleared to 0 on rst.
- Undefined:
  - dump_data is muxed combinationally from live reg_flat by dump_idx.
  - The integrator guarantees the registers are stable while cpu_rstn=0.

Test Plan:
- Normal completion: rst, start, completed asserted on the 10th RUN cycle; reg i = i*3 -> cycle_count=10, timeout=0, 32 words idx 0..31 with data i*3, dump_last only on idx 31, done=1.
- Timeout: MAX_CLOCKS=50, completed never set -> cycle_count=50, timeout=1, cpu_rstn=0 from the DUMP entry, full dump, done=1.
- Back-pressure: dump_ready toggled 1,0,0,1 repeating -> each word held stable while ready=0, no word lost or duplicated, 32 transfers total.
- Simultaneous: MAX_CLOCKS=20, completed on the 20th cycle -> timeout=0, cycle_count=20.
- Reset mid-dump: rst after 5 transfers -> all outputs at reset values next cycle; a new start then gives a full dump from idx 0.
- Snapshot (RUN_MONITOR_SNAPSHOT_EN): reg_flat forced to all-zero after DUMP entry -> dumped values equal pre-transition values; without the macro, zeros are dumped.
